// File: rtl/strobe_pkg.sv
// strobe_pkg
//   Shared definitions for the strobe bundle generator: the controller
//   state encoding, the lane count and the default divide-ratio width.
package strobe_pkg;

    localparam int NUM_LANES     = 4;
    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_RUN   = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    // Lanes count and strobe only while running or draining.
    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/strobe_lane.sv
// strobe_lane
//   One strobe lane: a latched divide ratio, a free-running counter and
//   the strobe decode. A latched ratio of 0 behaves as a ratio of 1.
// Ports
//   clk      sole clock
//   rst_n    asynchronous active-low reset
//   load     latch div_in and clear the counter (controller in ARM)
//   div_in   divide ratio for this lane
//   run_now  controller currently in RUN or DRAIN
//   run_next controller will be in RUN or DRAIN next cycle
//   strobe   high on the last count of each period while running
module strobe_lane #(
    parameter int DIV_W = strobe_pkg::DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    input  logic             run_now,
    input  logic             run_next,
    output logic             strobe
);

    logic [DIV_W-1:0] ratio_reg;
    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;
    logic [DIV_W-1:0] last_count;

    // Ratio 0 and ratio 1 both wrap at count 0.
    assign last_count = (ratio_reg == '0) ? '0 : (ratio_reg - DIV_W'(1));
    assign strobe     = run_now && (count_reg == last_count);

    // The counter is zero whenever the lane is not counting into the next
    // cycle, so it sits at 0 through IDLE and ARM and starts RUN from 0.
    always_comb begin
        count_next = '0;
        if (run_now && run_next) begin
            count_next = strobe ? '0 : (count_reg + DIV_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_reg <= '0;
            count_reg <= '0;
        end else begin
            if (load) begin
                ratio_reg <= div_in;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/strobe_bundle_gen.sv
// strobe_bundle_gen
//   Generates a bundle of divided strobes after a start request, keeps
//   running until a stop request, then drains until the next master
//   (lane 3) strobe before returning to idle with a one-cycle done pulse.
// Ports
//   clk        sole clock
//   rst_n      asynchronous active-low reset
//   i_start    single-cycle start request (honoured in IDLE only)
//   i_stop     single-cycle stop request (honoured in RUN; wins over start in IDLE)
//   i_div      packed lane ratios, lane k = i_div[k*DIV_W +: DIV_W]
//   i_data     serial data captured on lane 0 strobes
//   o_strobes  strobe bundle, bit 3 is the master strobe
//   o_data_q   last captured i_data
//   o_state    controller state encoding
//   o_busy     high outside IDLE
//   o_done     one-cycle pulse in the first IDLE cycle after DRAIN
module strobe_bundle_gen #(
    parameter int DIV_W     = strobe_pkg::DIV_W_DEFAULT,
    parameter int NUM_LANES = strobe_pkg::NUM_LANES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic [NUM_LANES*DIV_W-1:0] i_div,
    input  logic                       i_data,
    output logic [NUM_LANES-1:0]       o_strobes,
    output logic                       o_data_q,
    output logic [1:0]                 o_state,
    output logic                       o_busy,
    output logic                       o_done
);
    import strobe_pkg::*;

    state_t               state_reg;
    state_t               state_next;
    logic                 done_reg;
    logic                 done_next;
    logic                 data_q_reg;
    logic [NUM_LANES-1:0] strobes;
    logic                 run_now;
    logic                 run_next;
    logic                 load;

    assign run_now  = is_active(state_reg);
    assign run_next = is_active(state_next);
    assign load     = (state_reg == ST_ARM);

    // Only a master strobe seen while already in DRAIN ends the drain, so a
    // master strobe in the same cycle the stop is sampled does not count.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (strobes[NUM_LANES-1]) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            strobe_lane #(
                .DIV_W (DIV_W)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (load),
                .div_in   (i_div[gi*DIV_W +: DIV_W]),
                .run_now  (run_now),
                .run_next (run_next),
                .strobe   (strobes[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            done_reg   <= 1'b0;
            data_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (strobes[0]) begin
                data_q_reg <= i_data;
            end
        end
    end

    assign o_strobes = strobes;
    assign o_data_q  = data_q_reg;
    assign o_state   = state_reg;
    assign o_busy    = (state_reg != ST_IDLE);
    assign o_done    = done_reg;

endmodule

// File: tb/tb_strobe_bundle_gen.sv
module tb_strobe_bundle_gen;

    localparam int DIV_W = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop  = 1'b0;
    logic        i_data  = 1'b0;
    logic [31:0] i_div   = '0;
    logic [3:0]  o_strobes;
    logic        o_data_q;
    logic [1:0]  o_state;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    strobe_bundle_gen #(
        .DIV_W     (DIV_W),
        .NUM_LANES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_div     (i_div),
        .i_data    (i_data),
        .o_strobes (o_strobes),
        .o_data_q  (o_data_q),
        .o_state   (o_state),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase (0 idle, 1 arm, 2 run, 3 drain), number of
    // cycles since RUN began, and the effective ratios. A lane strobes when
    // the running cycle index t satisfies (t+1) mod d == 0.
    // ------------------------------------------------------------------
    int   m_state;
    int   m_t;
    int   m_d [4];
    logic m_done;
    logic m_dq;

    function automatic logic [3:0] m_strobes();
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s[k] = (m_state >= 2) && (((m_t + 1) % m_d[k]) == 0);
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_t     <= 0;
            for (int k = 0; k < 4; k++) m_d[k] <= 1;
            m_done  <= 1'b0;
            m_dq    <= 1'b0;
        end else begin
            m_done <= (m_state == 3) && m_strobes()[3];
            if (m_strobes()[0]) m_dq <= i_data;
            case (m_state)
                0: if (i_start && !i_stop) m_state <= 1;
                1: begin
                    for (int k = 0; k < 4; k++)
                        m_d[k] <= (i_div[k*8 +: 8] == 0) ? 1 : int'(i_div[k*8 +: 8]);
                    m_t     <= 0;
                    m_state <= 2;
                end
                2: begin
                    m_t <= m_t + 1;
                    if (i_stop) m_state <= 3;
                end
                default: begin
                    m_t <= m_t + 1;
                    if (m_strobes()[3]) m_state <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state",   o_state,   m_state[1:0]);
            check("strobes", o_strobes, m_strobes());
            check("busy",    o_busy,    m_state != 0);
            check("done",    o_done,    m_done);
            check("data_q",  o_data_q,  m_dq);
        end
    end

    // ------------------------------------------------------------------
    // One start..done transaction. Cycle c = RUN cycle index. Records per
    // cycle lane 0 / lane 3 strobes, drain occupancy and o_data_q.
    // ------------------------------------------------------------------
    task automatic run_case(input logic [31:0] div, input int stop_at, input int rst_at,
                            input bit rnd, output logic [31:0] m0, output logic [31:0] m3,
                            output logic [31:0] md, output logic [31:0] mq,
                            output int done_cyc);
        m0 = '0; m3 = '0; md = '0; mq = '0; done_cyc = -1;
        i_div   = div;
        i_start = 1'b1;
        i_stop  = 1'b0;
        @(posedge clk); #1;
        i_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        i_stop  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            if (c < 32) begin
                m0[c] = o_strobes[0];
                m3[c] = o_strobes[3];
                md[c] = (o_state == 2'b11);
                mq[c] = o_data_q;
            end
            if (o_done) begin
                done_cyc = c;
                break;
            end
            i_data  = rnd ? 1'($urandom_range(0, 1)) : c[0];
            i_stop  = (c == stop_at) || (rnd && c > stop_at && $urandom_range(0, 3) == 0);
            i_start = rnd && ($urandom_range(0, 3) == 0);
            if (rnd) i_div = $urandom;
            if (c == rst_at) begin
                check("pre_rst_data_q", o_data_q, 1);
                #2 rst_n = 1'b0;
                #1;
                check("rst_state",   o_state,   0);
                check("rst_strobes", o_strobes, 0);
                check("rst_busy",    o_busy,    0);
                check("rst_done",    o_done,    0);
                check("rst_data_q",  o_data_q,  0);
                i_start = 1'b0;
                i_stop  = 1'b0;
                @(posedge clk); #3;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    function automatic int expect_done(input logic [31:0] div, input int stop_at);
        int d3;
        int e;
        d3 = (div[31:24] == 0) ? 1 : int'(div[31:24]);
        e  = stop_at + 1;
        while (((e + 1) % d3) != 0) e++;
        return e + 1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m0, m3, md, mq, dv;
        int          dc;
        int          sa;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state",   o_state,   0);
        check("reset_strobes", o_strobes, 0);
        check("reset_busy",    o_busy,    0);
        check("reset_done",    o_done,    0);
        check("reset_data_q",  o_data_q,  0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        // Start and stop together in IDLE: nothing happens.
        i_start = 1'b1; i_stop = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ss_state",   o_state,   0);
            check("ss_strobes", o_strobes, 0);
            check("ss_done",    o_done,    0);
            $display("txn start+stop idle cycle %0d state=%0d", i, o_state);
            @(posedge clk); #1;
        end

        // Reset in DRAIN, then no done pulse.
        run_case(32'h08010101, 1, 4, 1'b0, m0, m3, md, mq, dc);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_done",  o_done,  0);
            check("post_rst_state", o_state, 0);
            @(posedge clk); #1;
        end
        $display("txn reset mid-drain: aborted");

        // Ratios {4,2,1,3}, stop in RUN cycle 11 (also restart after reset).
        run_case(32'h04020103, 11, -1, 1'b0, m0, m3, md, mq, dc);
        check("r034_lane0", m0 & 32'h0FFF, 32'h0924);
        check("r034_lane3", m3 & 32'hFFFF, 32'h8888);
        check("r034_drain", md, 32'h0000F000);
        check("r034_done",  dc, 16);
        check("r039_dataq", mq & 32'hFFF8, 32'h71C0);
        $display("txn ratios 4,2,1,3 stop@11 done@%0d", dc);

        // All ratios 0 behave as 1.
        run_case(32'h00000000, 3, -1, 1'b0, m0, m3, md, mq, dc);
        check("r036_lane0", m0, 32'h1F);
        check("r036_lane3", m3, 32'h1F);
        check("r036_drain", md, 32'h10);
        check("r036_done",  dc, 5);
        $display("txn ratios 0 stop@3 done@%0d", dc);

        // Lane 3 ratio 5, stop coincident with a lane 3 strobe.
        run_case(32'h05010101, 4, -1, 1'b0, m0, m3, md, mq, dc);
        check("r037_lane3", m3, 32'h210);
        check("r037_drain", md, 32'h3E0);
        check("r037_done",  dc, 10);
        $display("txn lane3 ratio 5 stop@4 done@%0d", dc);

        // Randomized transactions with ignored start/stop/div noise.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                i_stop = 1'($urandom_range(0, 1));
                i_data = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            i_stop = 1'b0;
            dv = '0;
            for (int k = 0; k < 4; k++) dv[k*8 +: 8] = 8'($urandom_range(0, 6));
            sa = $urandom_range(0, 15);
            run_case(dv, sa, -1, 1'b1, m0, m3, md, mq, dc);
            check("rand_done_cycle", dc, expect_done(dv, sa));
            $display("txn random %0d div=0x%08h stop@%0d done@%0d", n, dv, sa, dc);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/strobe_bundle_gen.md
STROBE_BUNDLE_GEN -- requirements
Module: strobe_bundle_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of each lane divide ratio.
REQ-002 Parameter NUM_LANES, default 4, number of strobe lanes; fixed at 4 for this release.
REQ-003 clk  input  1  sole clock; all state in this clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_start  input  1  single-cycle request to start strobing.
REQ-006 i_stop  input  1  single-cycle request to stop strobing.
REQ-007 i_div  input  4*DIV_W  packed lane divide ratios; lane k = i_div[k*DIV_W +: DIV_W].
REQ-008 i_data  input  1  serial data sampled on lane 0 strobe.
REQ-009 o_strobes  output  4  strobe bundle; bit 3 is the master strobe for the downstream consumer.
REQ-010 o_data_q  output  1  last i_data value captured.
REQ-011 o_state  output  2  current FSM state encoding.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_done  output  1  one-cycle pulse on completion of drain.

Function
REQ-014 FSM states SHALL be IDLE=2'b00, ARM=2'b01, RUN=2'b10, DRAIN=2'b11.
REQ-015 IDLE: i_start=1 and i_stop=0 -> ARM; i_stop has priority, so start+stop together -> stay IDLE.
REQ-016 ARM SHALL last exactly one cycle, latch i_div into per-lane registers, clear all lane counters, then -> RUN.
REQ-017 A latched divide ratio of 0 SHALL be treated as 1.
REQ-018 RUN/DRAIN: each lane counter increments every cycle from 0 to d-1 and wraps to 0 (d = latched ratio).
REQ-019 o_strobes[k] SHALL equal (state is RUN or DRAIN) AND (lane k counter == d_k-1), decoded from registered state only.
REQ-020 First strobe of lane k SHALL occur in RUN cycle d_k-1 (cycle 0 = first RUN cycle); d_k=1 gives a strobe every RUN cycle.
REQ-021 i_start in ARM, RUN or DRAIN SHALL be ignored; i_div changes outside ARM SHALL have no effect.
REQ-022 RUN: i_stop=1 -> DRAIN next cycle; counters continue without reset.
REQ-023 DRAIN SHALL persist until a cycle in which o_strobes[3]=1, then -> IDLE next cycle.
REQ-024 A lane 3 strobe coincident with the i_stop sampling cycle SHALL NOT end DRAIN; the next lane 3 strobe ends it.
REQ-025 o_done SHALL be high for exactly the first IDLE cycle after DRAIN, and never otherwise.
REQ-026 i_stop in IDLE, ARM or DRAIN SHALL be ignored (ARM still proceeds to RUN).
REQ-027 o_data_q SHALL load i_data on the clock edge ending any cycle with o_strobes[0]=1, else hold.
REQ-028 IDLE: all counters SHALL hold 0 and o_strobes SHALL be 4'b0000.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, counters 0, latched ratios 0, o_strobes 0, o_data_q 0, o_busy 0, o_done 0.
REQ-030 Reset mid-RUN or mid-DRAIN SHALL abort without an o_done pulse; the first cycle after deassertion is IDLE.

Structure
REQ-031 Package strobe_pkg SHALL hold the state enum type, NUM_LANES=4, and the default DIV_W.
REQ-032 One sub-module strobe_lane (latched ratio, counter, strobe decode) SHALL be instantiated 4 times by generate.
REQ-033 FSM, data capture and o_done SHALL live in strobe_bundle_gen.

Verification
REQ-034 Ratios {4,2,1,3} (lane3..0), start, stop after 12 RUN cycles -> lane0 strobes at RUN cycles 2,5,8,11; lane3 at 3,7,11; drain ends at cycle 15; o_done next cycle.
REQ-035 Start and stop asserted together in IDLE -> state stays 2'b00, o_strobes stay 0, no o_done.
REQ-036 All ratios 0 -> all four strobes high in every RUN cycle; stop -> DRAIN ends on the next cycle.
REQ-037 Lane 3 ratio 5, stop sampled in RUN cycle 4 (lane 3 strobe) -> DRAIN through cycle 9, IDLE at cycle 10 with o_done=1.
REQ-038 rst_n pulled low mid-DRAIN -> outputs zero asynchronously, no o_done, restart works normally.
REQ-039 i_data toggling every cycle, lane 0 ratio 3 -> o_data_q updates only after lane 0 strobe cycles.
